// File: rtl/cmult3_feeder_pkg.sv
// Shared definitions for the three-slot complex multiply feeder:
// Q-format defaults, word-width derivation and FSM state encoding.
package cmult3_feeder_pkg;

  localparam int QI_DEF = 3;
  localparam int QF_DEF = 3;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_MUL     = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  // Total word width of a signed Q(qi).(qf) value, sign bit counted in qi.
  function automatic int width_of(input int qi, input int qf);
    return qi + qf;
  endfunction

endpackage

// File: rtl/cmul_round_q.sv
// Combinational complex multiply (x * w) with round-half-up back to Q(QI).(QF).
// Build option CMULT3_FEEDER_SAT_EN: out-of-range results saturate; otherwise
// they wrap to the low WIDTH bits. The overflow flag is identical in both builds.
module cmul_round_q
  import cmult3_feeder_pkg::*;
#(
  parameter int QI = QI_DEF,
  parameter int QF = QF_DEF,
  localparam int W = width_of(QI, QF)
) (
  input  logic signed [W-1:0] i_xr,
  input  logic signed [W-1:0] i_xi,
  input  logic signed [W-1:0] i_wr,
  input  logic signed [W-1:0] i_wi,
  output logic signed [W-1:0] o_re,
  output logic signed [W-1:0] o_im,
  output logic                o_ovf
);

  // Full-precision width: two W-bit products summed need 2W+1 bits.
  localparam int PW = 2 * W + 1;
  localparam logic signed [PW-1:0] HALF = PW'(2 ** (QF - 1));
  localparam logic signed [PW-1:0] MAXV = PW'(2 ** (W - 1) - 1);
  localparam logic signed [PW-1:0] MINV = PW'(-(2 ** (W - 1)));

  logic signed [PW-1:0] w_xr, w_xi, w_wr, w_wi;
  logic signed [PW-1:0] w_re_full, w_im_full;
  logic signed [PW-1:0] w_re_rnd, w_im_rnd;
  logic                 w_re_hi, w_re_lo, w_im_hi, w_im_lo;

  assign w_xr = PW'(i_xr);
  assign w_xi = PW'(i_xi);
  assign w_wr = PW'(i_wr);
  assign w_wi = PW'(i_wi);

  assign w_re_full = w_xr * w_wr - w_xi * w_wi;
  assign w_im_full = w_xr * w_wi + w_xi * w_wr;

  // Adding half an LSB before the arithmetic shift gives round-half-up.
  assign w_re_rnd = (w_re_full + HALF) >>> QF;
  assign w_im_rnd = (w_im_full + HALF) >>> QF;

  assign w_re_hi = (w_re_rnd > MAXV);
  assign w_re_lo = (w_re_rnd < MINV);
  assign w_im_hi = (w_im_rnd > MAXV);
  assign w_im_lo = (w_im_rnd < MINV);

  assign o_ovf = w_re_hi | w_re_lo | w_im_hi | w_im_lo;

`ifdef CMULT3_FEEDER_SAT_EN
  assign o_re = w_re_hi ? MAXV[W-1:0] : (w_re_lo ? MINV[W-1:0] : w_re_rnd[W-1:0]);
  assign o_im = w_im_hi ? MAXV[W-1:0] : (w_im_lo ? MINV[W-1:0] : w_im_rnd[W-1:0]);
`else
  assign o_re = w_re_rnd[W-1:0];
  assign o_im = w_im_rnd[W-1:0];
`endif

endmodule

// File: rtl/cmult3_feeder.sv
// Collects three complex samples, multiplies each by its slot coefficient
// through one shared multiplier, then holds the three products for the sink.
// Build option CMULT3_FEEDER_SAT_EN selects saturation in cmul_round_q.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_COLLECT | in_ready high, samples land in slot[cnt], coefs at slot 0
//   ST_MUL     | one product per cycle, slot order 0,1,2
//   ST_HOLD    | products + overflow presented; out_valid rises one cycle
//              | after entry and stays until out_ready
module cmult3_feeder
  import cmult3_feeder_pkg::*;
#(
  parameter int QI = QI_DEF,
  parameter int QF = QF_DEF,
  localparam int WIDTH = width_of(QI, QF)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_Re,
  input  logic signed [WIDTH-1:0] in_Im,
  input  logic signed [WIDTH-1:0] w0_Re,
  input  logic signed [WIDTH-1:0] w0_Im,
  input  logic signed [WIDTH-1:0] w1_Re,
  input  logic signed [WIDTH-1:0] w1_Im,
  input  logic signed [WIDTH-1:0] w2_Re,
  input  logic signed [WIDTH-1:0] w2_Im,
  output logic signed [WIDTH-1:0] a_Re,
  output logic signed [WIDTH-1:0] a_Im,
  output logic signed [WIDTH-1:0] b_Re,
  output logic signed [WIDTH-1:0] b_Im,
  output logic signed [WIDTH-1:0] c_Re,
  output logic signed [WIDTH-1:0] c_Im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overflow
);

  state_t r_state, w_state_nxt;
  logic [1:0] r_cnt, r_mcnt;
  logic signed [WIDTH-1:0] r_x_re [3];
  logic signed [WIDTH-1:0] r_x_im [3];
  logic signed [WIDTH-1:0] r_w_re [3];
  logic signed [WIDTH-1:0] r_w_im [3];
  logic signed [WIDTH-1:0] r_a_re, r_a_im, r_b_re, r_b_im, r_c_re, r_c_im;
  logic r_ovf, r_out_valid;
  logic signed [WIDTH-1:0] w_op_xr, w_op_xi, w_op_wr, w_op_wi, w_p_re, w_p_im;
  logic w_p_ovf, w_accept;

  // in_ready is gated by rst so it is low during reset and high the first
  // cycle after release, without waiting for an extra register stage.
  assign in_ready = (r_state == ST_COLLECT) && !rst;
  assign w_accept = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_COLLECT;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_COLLECT: if (w_accept && (r_cnt == 2'd2)) w_state_nxt = ST_MUL;
      ST_MUL:     if (r_mcnt == 2'd2) w_state_nxt = ST_HOLD;
      ST_HOLD:    if (r_out_valid && out_ready) w_state_nxt = ST_COLLECT;
      default:    w_state_nxt = ST_COLLECT;
    endcase
  end

  // Operand select for the shared multiplier, driven by the MUL slot counter.
  always_comb begin
    w_op_xr = r_x_re[0];
    w_op_xi = r_x_im[0];
    w_op_wr = r_w_re[0];
    w_op_wi = r_w_im[0];
    case (r_mcnt)
      2'd1: begin
        w_op_xr = r_x_re[1]; w_op_xi = r_x_im[1];
        w_op_wr = r_w_re[1]; w_op_wi = r_w_im[1];
      end
      2'd2: begin
        w_op_xr = r_x_re[2]; w_op_xi = r_x_im[2];
        w_op_wr = r_w_re[2]; w_op_wi = r_w_im[2];
      end
      default: ;
    endcase
  end

  cmul_round_q #(.QI(QI), .QF(QF)) u_cmul (
    .i_xr  (w_op_xr),
    .i_xi  (w_op_xi),
    .i_wr  (w_op_wr),
    .i_wi  (w_op_wi),
    .o_re  (w_p_re),
    .o_im  (w_p_im),
    .o_ovf (w_p_ovf)
  );

  // Slot capture, coefficient latch, product registers, overflow and out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_mcnt      <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_a_re <= '0; r_a_im <= '0;
      r_b_re <= '0; r_b_im <= '0;
      r_c_re <= '0; r_c_im <= '0;
      for (int k = 0; k < 3; k++) begin
        r_x_re[k] <= '0; r_x_im[k] <= '0;
        r_w_re[k] <= '0; r_w_im[k] <= '0;
      end
    end else begin
      if (w_accept) begin
        case (r_cnt)
          2'd0: begin
            r_x_re[0] <= in_Re; r_x_im[0] <= in_Im;
            r_w_re[0] <= w0_Re; r_w_im[0] <= w0_Im;
            r_w_re[1] <= w1_Re; r_w_im[1] <= w1_Im;
            r_w_re[2] <= w2_Re; r_w_im[2] <= w2_Im;
            r_ovf     <= 1'b0;
          end
          2'd1:    begin r_x_re[1] <= in_Re; r_x_im[1] <= in_Im; end
          default: begin r_x_re[2] <= in_Re; r_x_im[2] <= in_Im; end
        endcase
        r_cnt <= (r_cnt == 2'd2) ? 2'd0 : r_cnt + 2'd1;
      end

      if (r_state == ST_MUL) begin
        case (r_mcnt)
          2'd0:    begin r_a_re <= w_p_re; r_a_im <= w_p_im; end
          2'd1:    begin r_b_re <= w_p_re; r_b_im <= w_p_im; end
          default: begin r_c_re <= w_p_re; r_c_im <= w_p_im; end
        endcase
        r_ovf  <= r_ovf | w_p_ovf;
        r_mcnt <= (r_mcnt == 2'd2) ? 2'd0 : r_mcnt + 2'd1;
      end

      if ((r_state == ST_HOLD) && !r_out_valid) r_out_valid <= 1'b1;
      else if (r_out_valid && out_ready)        r_out_valid <= 1'b0;
    end
  end

  assign a_Re      = r_a_re;
  assign a_Im      = r_a_im;
  assign b_Re      = r_b_re;
  assign b_Im      = r_b_im;
  assign c_Re      = r_c_re;
  assign c_Im      = r_c_im;
  assign overflow  = r_ovf;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_cmult3_feeder.sv
// Self-checking bench for cmult3_feeder (QI=3, QF=3, 1.0 = 8).
// Honours CMULT3_FEEDER_SAT_EN for the expected out-of-range behaviour.
module tb_cmult3_feeder;

  localparam int QI   = 3;
  localparam int QF   = 3;
  localparam int W    = QI + QF;
  localparam int MAXV = (1 << (W - 1)) - 1;
  localparam int MINV = -(1 << (W - 1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid, in_ready, out_valid, out_ready, overflow;
  logic signed [W-1:0] in_Re, in_Im;
  logic signed [W-1:0] w0_Re, w0_Im, w1_Re, w1_Im, w2_Re, w2_Im;
  logic signed [W-1:0] a_Re, a_Im, b_Re, b_Im, c_Re, c_Im;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct packed {
    int ar; int ai; int br; int bi; int cr; int ci;
    bit ovf;
    int acc;
  } exp_t;
  exp_t exp_q[$];

  int f_xr[3], f_xi[3], f_wr[3], f_wi[3];

  cmult3_feeder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_Re(in_Re), .in_Im(in_Im),
    .w0_Re(w0_Re), .w0_Im(w0_Im), .w1_Re(w1_Re), .w1_Im(w1_Im),
    .w2_Re(w2_Re), .w2_Im(w2_Im),
    .a_Re(a_Re), .a_Im(a_Im), .b_Re(b_Re), .b_Im(b_Im),
    .c_Re(c_Re), .c_Im(c_Im),
    .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int reduce(input int v);
`ifdef CMULT3_FEEDER_SAT_EN
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
`else
    int t;
    t = v & ((1 << W) - 1);
    if (t > MAXV) t = t - (1 << W);
    return t;
`endif
  endfunction

  // Reference: exact complex product, round half up, range test, reduce.
  function automatic void cmodel(input int xr, input int xi, input int wr, input int wi,
                                 output int re, output int im, output bit ovf);
    int fr, fi;
    fr  = (xr * wr - xi * wi + (1 << (QF - 1))) >>> QF;
    fi  = (xr * wi + xi * wr + (1 << (QF - 1))) >>> QF;
    ovf = (fr > MAXV) || (fr < MINV) || (fi > MAXV) || (fi < MINV);
    re  = reduce(fr);
    im  = reduce(fi);
  endfunction

  task automatic drive_w_from_frame();
    w0_Re = W'(f_wr[0]); w0_Im = W'(f_wi[0]);
    w1_Re = W'(f_wr[1]); w1_Im = W'(f_wi[1]);
    w2_Re = W'(f_wr[2]); w2_Im = W'(f_wi[2]);
  endtask

  // Sends the three samples in f_*; with scramble, coefficient inputs are
  // randomised after slot 0 so only the slot-0 snapshot may be used.
  task automatic send_frame(input bit scramble);
    exp_t e;
    int r, i, t;
    bit o;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_Re = W'(f_xr[k]);
      in_Im = W'(f_xi[k]);
      if (k == 0 || !scramble) drive_w_from_frame();
      else begin
        w0_Re = W'($urandom); w0_Im = W'($urandom);
        w1_Re = W'($urandom); w1_Im = W'($urandom);
        w2_Re = W'($urandom); w2_Im = W'($urandom);
      end
      t = 0;
      while (!in_ready && t < 50) begin @(negedge clk); t++; end
      if (!in_ready) begin
        chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    e = '0;
    cmodel(f_xr[0], f_xi[0], f_wr[0], f_wi[0], r, i, o); e.ar = r; e.ai = i; e.ovf = o;
    cmodel(f_xr[1], f_xi[1], f_wr[1], f_wi[1], r, i, o); e.br = r; e.bi = i; e.ovf = e.ovf | o;
    cmodel(f_xr[2], f_xi[2], f_wr[2], f_wi[2], r, i, o); e.cr = r; e.ci = i; e.ovf = e.ovf | o;
    e.acc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic wait_out();
    int t;
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 20) begin @(negedge clk); t++; end
    chk("out_valid_timeout", int'(out_valid), 1);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_after_release", int'(out_valid), 0);
    chk("in_ready_after_release", int'(in_ready), 1);
  endtask

  // Retire the expected frame on the output handshake.
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready && exp_q.size() > 0) exp_q.delete(0);
  end

  // Compare every cycle the outputs are valid against the model's frame.
  bit prev_ov = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) prev_ov = 1'b0;
    else begin
      if (out_valid) begin
        if (exp_q.size() == 0) chk("unexpected_out_valid", 1, 0);
        else begin
          e = exp_q[0];
          chk("m_a_Re", int'(a_Re), e.ar);
          chk("m_a_Im", int'(a_Im), e.ai);
          chk("m_b_Re", int'(b_Re), e.br);
          chk("m_b_Im", int'(b_Im), e.bi);
          chk("m_c_Re", int'(c_Re), e.cr);
          chk("m_c_Im", int'(c_Im), e.ci);
          chk("m_overflow", int'(overflow), int'(e.ovf));
          chk("m_in_ready_low", int'(in_ready), 0);
          if (!prev_ov) chk("m_out_latency", cyc - e.acc, 4);
        end
      end
      prev_ov = out_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nov;
    in_valid = 1'b0; out_ready = 1'b0;
    in_Re = '0; in_Im = '0;
    w0_Re = '0; w0_Im = '0; w1_Re = '0; w1_Im = '0; w2_Re = '0; w2_Im = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_a_Re", int'(a_Re), 0);
    chk("rst_c_Im", int'(c_Im), 0);
    rst = 1'b0;
    #1;
    chk("in_ready_first_cycle", int'(in_ready), 1);
    @(negedge clk);
    chk("in_ready_after_edge", int'(in_ready), 1);

    // Identity coefficients.
    f_xr = '{8, 0, -8}; f_xi = '{0, 8, 0};
    f_wr = '{8, 8, 8};  f_wi = '{0, 0, 0};
    send_frame(1'b0);
    wait_out();
    chk("id_a_Re", int'(a_Re), 8);  chk("id_a_Im", int'(a_Im), 0);
    chk("id_b_Re", int'(b_Re), 0);  chk("id_b_Im", int'(b_Im), 8);
    chk("id_c_Re", int'(c_Re), -8); chk("id_c_Im", int'(c_Im), 0);
    chk("id_overflow", int'(overflow), 0);
    release_out();

    // j*j, rounding, overflow; then 5 cycles of backpressure with stray in_valid.
    f_xr = '{0, 1, 31}; f_xi = '{8, 0, 0};
    f_wr = '{0, 4, 31}; f_wi = '{8, 0, 0};
    send_frame(1'b0);
    wait_out();
    chk("jj_a_Re", int'(a_Re), -8); chk("jj_a_Im", int'(a_Im), 0);
    chk("rnd_b_Re", int'(b_Re), 1); chk("rnd_b_Im", int'(b_Im), 0);
`ifdef CMULT3_FEEDER_SAT_EN
    chk("ovf_c_Re", int'(c_Re), 31);
`else
    chk("ovf_c_Re", int'(c_Re), -8);
`endif
    chk("ovf_flag", int'(overflow), 1);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_Re = W'(5 + k); in_Im = W'(-3);
      @(negedge clk);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_a_Re", int'(a_Re), -8);
    end
    in_valid = 1'b0;
    release_out();

    // Coefficients must come from the slot-0 snapshot; overflow cleared.
    f_xr = '{3, -7, 12}; f_xi = '{-5, 2, 9};
    f_wr = '{5, -4, 2};  f_wi = '{3, 6, -8};
    send_frame(1'b1);
    wait_out();
    chk("cl_a_Re", int'(a_Re), 4);  chk("cl_a_Im", int'(a_Im), -2);
    chk("cl_b_Re", int'(b_Re), 2);  chk("cl_b_Im", int'(b_Im), -6);
    chk("cl_c_Re", int'(c_Re), 12); chk("cl_c_Im", int'(c_Im), -10);
    chk("cl_overflow", int'(overflow), 0);
    release_out();

    // Reset pulsed in the second MUL cycle aborts the frame.
    f_xr = '{1, 2, 3}; f_xi = '{4, 5, 6};
    f_wr = '{8, 8, 8}; f_wi = '{0, 0, 0};
    send_frame(1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    nov = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) nov++;
    end
    chk("abort_no_out_valid", nov, 0);
    chk("abort_in_ready", int'(in_ready), 1);

    // Clean frame after the abort.
    f_xr = '{-8, 8, 4}; f_xi = '{8, -8, 4};
    f_wr = '{8, 8, 8};  f_wi = '{0, 0, 0};
    send_frame(1'b0);
    wait_out();
    chk("post_a_Re", int'(a_Re), -8); chk("post_a_Im", int'(a_Im), 8);
    chk("post_b_Re", int'(b_Re), 8);  chk("post_b_Im", int'(b_Im), -8);
    chk("post_c_Re", int'(c_Re), 4);  chk("post_c_Im", int'(c_Im), 4);
    release_out();

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
